// File: rtl/vending_pkg.sv
// Shared types and constants for the drink vending machine.
// Imported by the transaction controller and the display side.
package vending_pkg;

  localparam int CREDIT_W = 8;
  localparam int TMR_W    = 26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CREDIT,
    S_DISPENSE,
    S_CHANGE,
    S_FAULT
  } state_t;

  localparam logic [CREDIT_W-1:0] DEF_NOTE0  = 8'd2;
  localparam logic [CREDIT_W-1:0] DEF_NOTE1  = 8'd5;
  localparam logic [CREDIT_W-1:0] DEF_NOTE2  = 8'd10;
  localparam logic [CREDIT_W-1:0] DEF_PRICE0 = 8'd3;
  localparam logic [CREDIT_W-1:0] DEF_PRICE1 = 8'd4;
  localparam logic [CREDIT_W-1:0] DEF_PRICE2 = 8'd6;
  localparam logic [CREDIT_W-1:0] DEF_PRICE3 = 8'd8;
  localparam logic [CREDIT_W-1:0] DEF_CMAX   = 8'd20;

  function automatic logic is_busy(input state_t s);
    return (s == S_DISPENSE) || (s == S_CHANGE) || (s == S_FAULT);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done while the count sits at zero.
// Load wins over decrement; the count never wraps below zero.
module cycle_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/vending_transaction_fsm.sv
// Vending transaction controller: credit, selection, dispense, change.
// All outputs are registered alongside the state.
module vending_transaction_fsm
  import vending_pkg::*;
#(
  parameter logic [CREDIT_W-1:0] NOTE0_VAL    = DEF_NOTE0,
  parameter logic [CREDIT_W-1:0] NOTE1_VAL    = DEF_NOTE1,
  parameter logic [CREDIT_W-1:0] NOTE2_VAL    = DEF_NOTE2,
  parameter logic [CREDIT_W-1:0] PRICE0       = DEF_PRICE0,
  parameter logic [CREDIT_W-1:0] PRICE1       = DEF_PRICE1,
  parameter logic [CREDIT_W-1:0] PRICE2       = DEF_PRICE2,
  parameter logic [CREDIT_W-1:0] PRICE3       = DEF_PRICE3,
  parameter logic [CREDIT_W-1:0] CREDIT_MAX   = DEF_CMAX,
  parameter int unsigned         TIMEOUT_CYC  = 50_000_000,
  parameter int unsigned         DISPENSE_CYC = 25_000_000
) (
  input  logic                clk0,
  input  logic                reset,
  input  logic [3:0]          bt,
  input  logic [2:0]          note_pulse,
  input  logic                cancel,
  input  logic                V_sense,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          drink_sel,
  output logic                dispense,
  output logic [CREDIT_W-1:0] change_val,
  output logic                change_valid,
  output logic                note_reject,
  output logic                price_short,
  output logic                busy
);

  localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] DS_LOAD = TMR_W'(DISPENSE_CYC - 1);

  state_t              r_state, w_state_n;
  logic [CREDIT_W-1:0] r_credit, w_credit_n;
  logic [CREDIT_W-1:0] r_change, w_change_n;
  logic [1:0]          r_sel, w_sel_n;
  logic                r_disp, w_disp_n;
  logic                r_chg_v, w_chg_v_n;
  logic                r_rej, w_rej_n;
  logic                r_short, w_short_n;
  logic                r_busy;

  logic                w_note_hit, w_bt_hit;
  logic [CREDIT_W-1:0] w_note_val, w_price;
  logic [1:0]          w_bt_idx;
  logic [CREDIT_W:0]   w_sum;
  logic                w_to_load, w_to_en, w_to_done;
  logic                w_ds_load, w_ds_en, w_ds_done;

  assign w_note_hit = |note_pulse;
  assign w_bt_hit   = |bt;

  // Lowest index wins when several pulses coincide.
  always_comb begin
    w_note_val = '0;
    priority case (1'b1)
      note_pulse[0]: w_note_val = NOTE0_VAL;
      note_pulse[1]: w_note_val = NOTE1_VAL;
      note_pulse[2]: w_note_val = NOTE2_VAL;
      default:       w_note_val = '0;
    endcase
  end

  always_comb begin
    w_bt_idx = 2'd0;
    priority case (1'b1)
      bt[0]:   w_bt_idx = 2'd0;
      bt[1]:   w_bt_idx = 2'd1;
      bt[2]:   w_bt_idx = 2'd2;
      bt[3]:   w_bt_idx = 2'd3;
      default: w_bt_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_price = PRICE0;
    unique case (w_bt_idx)
      2'd0: w_price = PRICE0;
      2'd1: w_price = PRICE1;
      2'd2: w_price = PRICE2;
      2'd3: w_price = PRICE3;
      default: w_price = PRICE0;
    endcase
  end

  assign w_sum   = {1'b0, r_credit} + {1'b0, w_note_val};
  assign w_to_en = (r_state == S_CREDIT);
  assign w_ds_en = (r_state == S_DISPENSE);

  always_comb begin
    w_state_n  = r_state;
    w_credit_n = r_credit;
    w_sel_n    = r_sel;
    w_disp_n   = 1'b0;
    w_change_n = '0;
    w_chg_v_n  = 1'b0;
    w_rej_n    = 1'b0;
    w_short_n  = 1'b0;
    w_to_load  = 1'b0;
    w_ds_load  = 1'b0;
    if (V_sense && (r_state != S_FAULT)) begin
      w_state_n  = S_FAULT;
      w_credit_n = '0;
      w_change_n = r_credit;
      w_chg_v_n  = (r_credit != '0);
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_note_hit) begin
            w_credit_n = w_note_val;
            w_state_n  = S_CREDIT;
            w_to_load  = 1'b1;
          end else if (w_bt_hit) begin
            w_short_n = 1'b1;
          end
        end
        S_CREDIT: begin
          if (cancel) begin
            w_state_n  = S_CHANGE;
            w_change_n = r_credit;
            w_chg_v_n  = 1'b1;
            w_credit_n = '0;
          end else if (w_note_hit) begin
            w_to_load = 1'b1;
            if (w_sum <= {1'b0, CREDIT_MAX}) begin
              w_credit_n = w_sum[CREDIT_W-1:0];
            end else begin
              w_rej_n = 1'b1;
            end
          end else if (w_bt_hit) begin
            if (r_credit >= w_price) begin
              w_sel_n    = w_bt_idx;
              w_credit_n = r_credit - w_price;
              w_state_n  = S_DISPENSE;
              w_disp_n   = 1'b1;
              w_ds_load  = 1'b1;
            end else begin
              w_short_n = 1'b1;
              w_to_load = 1'b1;
            end
          end else if (w_to_done) begin
            w_state_n  = S_CHANGE;
            w_change_n = r_credit;
            w_chg_v_n  = 1'b1;
            w_credit_n = '0;
          end
        end
        S_DISPENSE: begin
          w_rej_n = w_note_hit;
          if (w_ds_done) begin
            w_state_n  = S_CHANGE;
            w_change_n = r_credit;
            w_chg_v_n  = 1'b1;
            w_credit_n = '0;
          end else begin
            w_disp_n = 1'b1;
          end
        end
        S_CHANGE: begin
          w_state_n  = S_IDLE;
          w_credit_n = '0;
        end
        S_FAULT: begin
          w_rej_n = w_note_hit;
          if (!V_sense) w_state_n = S_IDLE;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_change <= '0;
      r_sel    <= '0;
      r_disp   <= 1'b0;
      r_chg_v  <= 1'b0;
      r_rej    <= 1'b0;
      r_short  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_credit <= w_credit_n;
      r_change <= w_change_n;
      r_sel    <= w_sel_n;
      r_disp   <= w_disp_n;
      r_chg_v  <= w_chg_v_n;
      r_rej    <= w_rej_n;
      r_short  <= w_short_n;
      r_busy   <= is_busy(w_state_n);
    end
  end

  cycle_timer #(.W(TMR_W)) u_timeout (
    .clk    (clk0),
    .rst    (reset),
    .i_load (w_to_load),
    .i_val  (TO_LOAD),
    .i_en   (w_to_en),
    .o_done (w_to_done)
  );

  cycle_timer #(.W(TMR_W)) u_disp (
    .clk    (clk0),
    .rst    (reset),
    .i_load (w_ds_load),
    .i_val  (DS_LOAD),
    .i_en   (w_ds_en),
    .o_done (w_ds_done)
  );

  assign credit       = r_credit;
  assign drink_sel    = r_sel;
  assign dispense     = r_disp;
  assign change_val   = r_change;
  assign change_valid = r_chg_v;
  assign note_reject  = r_rej;
  assign price_short  = r_short;
  assign busy         = r_busy;

endmodule

// File: tb/tb_vending_transaction_fsm.sv
// Directed bench for the vending transaction controller.
// Expected values are hand-computed from the note/price tables.
module tb_vending_transaction_fsm;

  logic       clk0 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] bt = '0;
  logic [2:0] note_pulse = '0;
  logic       cancel = 1'b0;
  logic       V_sense = 1'b0;
  logic [7:0] credit;
  logic [1:0] drink_sel;
  logic       dispense;
  logic [7:0] change_val;
  logic       change_valid;
  logic       note_reject;
  logic       price_short;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk0 = ~clk0;

  vending_transaction_fsm #(
    .TIMEOUT_CYC  (20),
    .DISPENSE_CYC (4)
  ) dut (
    .clk0         (clk0),
    .reset        (reset),
    .bt           (bt),
    .note_pulse   (note_pulse),
    .cancel       (cancel),
    .V_sense      (V_sense),
    .credit       (credit),
    .drink_sel    (drink_sel),
    .dispense     (dispense),
    .change_val   (change_val),
    .change_valid (change_valid),
    .note_reject  (note_reject),
    .price_short  (price_short),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic pulse(input logic [3:0] b, input logic [2:0] n,
                       input logic c);
    bt = b;
    note_pulse = n;
    cancel = c;
    tick();
    bt = '0;
    note_pulse = '0;
    cancel = 1'b0;
  endtask

  initial begin
    #1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp", dispense, 0);
    chk("rst_chgv", change_valid, 0);
    chk("rst_sel", drink_sel, 0);

    // Test 1: 5 + 2, buy price 6
    pulse(4'b0000, 3'b010, 1'b0);
    chk("t1_c5", credit, 5);
    pulse(4'b0000, 3'b001, 1'b0);
    chk("t1_c7", credit, 7);
    pulse(4'b0100, 3'b000, 1'b0);
    chk("t1_sel", drink_sel, 2);
    chk("t1_c1", credit, 1);
    chk("t1_disp0", dispense, 1);
    chk("t1_busy", busy, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t1_disp", dispense, 1);
    end
    tick();
    chk("t1_disp_off", dispense, 0);
    chk("t1_chgv", change_valid, 1);
    chk("t1_chg", change_val, 1);
    chk("t1_c0", credit, 0);
    tick();
    chk("t1_chgv_off", change_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_cend", credit, 0);

    // IDLE selection is short
    pulse(4'b0001, 3'b000, 1'b0);
    chk("idle_short", price_short, 1);
    chk("idle_c", credit, 0);

    // Test 2: credit 7, price 8 short, cancel
    pulse(4'b0000, 3'b010, 1'b0);
    pulse(4'b0000, 3'b001, 1'b0);
    pulse(4'b1000, 3'b000, 1'b0);
    chk("t2_short", price_short, 1);
    chk("t2_c7", credit, 7);
    chk("t2_nodisp", dispense, 0);
    tick();
    chk("t2_short_off", price_short, 0);
    pulse(4'b0000, 3'b000, 1'b1);
    chk("t2_chgv", change_valid, 1);
    chk("t2_chg", change_val, 7);
    chk("t2_c0", credit, 0);
    tick();
    chk("t2_chgv_off", change_valid, 0);

    // Test 3: ceiling
    pulse(4'b0000, 3'b100, 1'b0);
    pulse(4'b0000, 3'b100, 1'b0);
    chk("t3_c20", credit, 20);
    chk("t3_norej", note_reject, 0);
    pulse(4'b0000, 3'b001, 1'b0);
    chk("t3_rej", note_reject, 1);
    chk("t3_c20b", credit, 20);
    pulse(4'b0000, 3'b000, 1'b1);
    chk("t3_chg", change_val, 20);
    tick();

    // Test 4: timeout refund
    pulse(4'b0000, 3'b010, 1'b0);
    chk("t4_c5", credit, 5);
    for (int i = 0; i < 19; i++) tick();
    chk("t4_wait_c", credit, 5);
    chk("t4_wait_v", change_valid, 0);
    tick();
    chk("t4_chgv", change_valid, 1);
    chk("t4_chg", change_val, 5);
    tick();
    chk("t4_idle", busy, 0);

    // Test 5: fault during dispense
    pulse(4'b0000, 3'b100, 1'b0);
    pulse(4'b0001, 3'b000, 1'b0);
    chk("t5_c7", credit, 7);
    chk("t5_disp", dispense, 1);
    tick();
    V_sense = 1'b1;
    tick();
    chk("t5_disp_off", dispense, 0);
    chk("t5_chgv", change_valid, 1);
    chk("t5_chg", change_val, 7);
    chk("t5_c0", credit, 0);
    chk("t5_busy", busy, 1);
    tick();
    chk("t5_chgv_off", change_valid, 0);
    chk("t5_busy2", busy, 1);
    pulse(4'b0000, 3'b001, 1'b0);
    chk("t5_rej", note_reject, 1);
    chk("t5_cf", credit, 0);
    V_sense = 1'b0;
    tick();
    chk("t5_idle", busy, 0);
    chk("t5_chgv_end", change_valid, 0);

    // Test 6: note beats bt; reset mid-dispense
    pulse(4'b0000, 3'b001, 1'b0);
    chk("t6_c2", credit, 2);
    pulse(4'b0001, 3'b001, 1'b0);
    chk("t6_c4", credit, 4);
    chk("t6_nodisp", dispense, 0);
    chk("t6_noshort", price_short, 0);
    pulse(4'b0010, 3'b000, 1'b0);
    chk("t6_sel", drink_sel, 1);
    chk("t6_c0", credit, 0);
    chk("t6_disp", dispense, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rdisp", dispense, 0);
    chk("t6_rbusy", busy, 0);
    chk("t6_rsel", drink_sel, 0);
    chk("t6_rchgv", change_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_nochg", change_valid, 0);
      chk("t6_nodisp2", dispense, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
